// File: rtl/serial_mag_compare_ctrl.sv
// serial_mag_compare_ctrl
// Consumes one {lt,gt,eq} flag triple per bit, MSB first, from a cascaded
// 1-bit comparator cell and resolves a WIDTH-bit magnitude comparison under
// a start/done handshake. Non-one-hot triples raise a sticky err that
// suppresses the result flags for that comparison.
module serial_mag_compare_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             bit_lt,
    input  logic             bit_gt,
    input  logic             bit_eq,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             res_lt,
    output logic             res_gt,
    output logic             res_eq,
    output logic             err,
    output logic [CNT_W-1:0] beat_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // Beat count at which the comparison is complete.
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH);

    state_t           r_state;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_res_lt;
    logic             r_res_gt;
    logic             r_res_eq;
    logic             r_err;
    logic             r_decided;
    logic             r_lt;
    logic             r_gt;
    logic [CNT_W-1:0] r_beat_cnt;

    logic             w_beat;
    logic             w_one_hot;
    logic             w_take_lt;
    logic             w_take_gt;
    logic             w_err_next;
    logic             w_lt_next;
    logic             w_gt_next;
    logic             w_last;
    logic [CNT_W-1:0] w_cnt_inc;

    // Classify the current triple and form the state this beat would produce.
    always_comb begin
        w_beat = in_valid & r_in_ready;
        case ({bit_lt, bit_gt, bit_eq})
            3'b100,
            3'b010,
            3'b001:  w_one_hot = 1'b1;
            default: w_one_hot = 1'b0;
        endcase
        // Only the first non-equal legal bit (MSB first) decides the outcome.
        w_take_lt  = w_one_hot & ~r_decided & bit_lt;
        w_take_gt  = w_one_hot & ~r_decided & bit_gt;
        w_err_next = r_err | ~w_one_hot;
        w_lt_next  = r_lt | w_take_lt;
        w_gt_next  = r_gt | w_take_gt;
        w_cnt_inc  = r_beat_cnt + CNT_W'(1);
        w_last     = (w_cnt_inc == LP_LAST);
    end

    // Control FSM with all handshake and result outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_res_lt   <= 1'b0;
            r_res_gt   <= 1'b0;
            r_res_eq   <= 1'b0;
            r_err      <= 1'b0;
            r_decided  <= 1'b0;
            r_lt       <= 1'b0;
            r_gt       <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    // A beat presented together with start is not taken:
                    // in_ready is still low in this cycle.
                    if (start) begin
                        r_state    <= S_COLLECT;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_beat_cnt <= '0;
                        r_decided  <= 1'b0;
                        r_lt       <= 1'b0;
                        r_gt       <= 1'b0;
                        r_err      <= 1'b0;
                    end
                end

                S_COLLECT: begin
                    // Beats after the decision are still consumed and checked
                    // so the beat framing stays aligned with the source.
                    if (w_beat) begin
                        r_beat_cnt <= w_cnt_inc;
                        r_err      <= w_err_next;
                        r_lt       <= w_lt_next;
                        r_gt       <= w_gt_next;
                        r_decided  <= r_decided | w_take_lt | w_take_gt;
                        if (w_last) begin
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
                            r_done     <= 1'b1;
                            r_res_lt   <= ~w_err_next & w_lt_next;
                            r_res_gt   <= ~w_err_next & w_gt_next;
                            r_res_eq   <= ~w_err_next & ~w_lt_next & ~w_gt_next;
                        end
                    end
                end

                S_DONE: begin
                    // start is ignored here; it is taken from IDLE next edge.
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign res_lt   = r_res_lt;
    assign res_gt   = r_res_gt;
    assign res_eq   = r_res_eq;
    assign err      = r_err;
    assign beat_cnt = r_beat_cnt;

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Self-checking bench for serial_mag_compare_ctrl. A behavioural model
// rebuilds the two operands from the accepted flag beats and compares them
// numerically; every cycle the DUT outputs are checked against it, and
// hand-computed literals pin the expected result of each directed case.
module tb_serial_mag_compare_ctrl;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          bit_lt = 1'b0;
    logic          bit_gt = 1'b0;
    logic          bit_eq = 1'b0;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic          res_lt;
    logic          res_gt;
    logic          res_eq;
    logic          err;
    logic [CW-1:0] beat_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    serial_mag_compare_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .bit_lt   (bit_lt),
        .bit_gt   (bit_gt),
        .bit_eq   (bit_eq),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .res_lt   (res_lt),
        .res_gt   (res_gt),
        .res_eq   (res_eq),
        .err      (err),
        .beat_cnt (beat_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Phase: 0 idle, 1 collecting, 2 result cycle.
    int         m_phase = 0;
    int         m_cnt   = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic       m_err = 1'b0;
    logic [2:0] m_res = 3'b000;   // {lt,gt,eq}

    function automatic logic [2:0] judge(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic e);
        if (e)         return 3'b000;
        else if (a < b) return 3'b100;
        else if (a > b) return 3'b010;
        else            return 3'b001;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_err   <= 1'b0;
            m_res   <= 3'b000;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase <= 1;
                m_cnt   <= 0;
                m_a     <= '0;
                m_b     <= '0;
                m_err   <= 1'b0;
            end
        end else if (m_phase == 1) begin
            if (in_valid) begin
                // A gt bit means A has 1 where B has 0; lt the reverse.
                m_a   <= {m_a[W-2:0], bit_gt};
                m_b   <= {m_b[W-2:0], bit_lt};
                m_err <= m_err | ($countones({bit_lt, bit_gt, bit_eq}) != 1);
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 == W) begin
                    m_phase <= 2;
                    m_res   <= judge({m_a[W-2:0], bit_gt}, {m_b[W-2:0], bit_lt},
                                     m_err | ($countones({bit_lt, bit_gt, bit_eq}) != 1));
                end
            end
        end else begin
            m_phase <= 0;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        chk("in_ready", CW'(in_ready), CW'(m_phase == 1));
        chk("busy",     CW'(busy),     CW'(m_phase != 0));
        chk("done",     CW'(done),     CW'(m_phase == 2));
        chk("res",      CW'({res_lt, res_gt, res_eq}), CW'(m_res));
        chk("err",      CW'(err),      CW'(m_err));
        chk("beat_cnt", beat_cnt,      CW'(m_cnt));
    endtask

    // Advance one cycle and compare against the model away from the edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        check_model();
    endtask

    function automatic logic [2:0] flags(input logic a, input logic b);
        if (a == b)  return 3'b001;
        else if (a)  return 3'b010;
        else         return 3'b100;
    endfunction

    // One full comparison; returns positioned in the result (done) cycle.
    task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit stall, input int bad_idx, input bit hold_start);
        start = 1'b1;
        in_valid = 1'b1;                // must not be accepted from IDLE
        {bit_lt, bit_gt, bit_eq} = 3'b010;
        step();
        chk("start_busy", CW'(busy), CW'(1));
        chk("start_err_clear", CW'(err), CW'(0));
        chk("start_cnt", beat_cnt, CW'(0));
        if (!hold_start) start = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i == bad_idx) {bit_lt, bit_gt, bit_eq} = 3'b110;
            else              {bit_lt, bit_gt, bit_eq} = flags(a[W-1-i], b[W-1-i]);
            in_valid = 1'b1;
            step();
            if (stall && i < W - 1) begin
                in_valid = 1'b0;
                {bit_lt, bit_gt, bit_eq} = 3'b111;   // ignored: not valid
                step();
                if (i == 0) chk("stall_cnt", beat_cnt, CW'(1));
            end
        end
        in_valid = 1'b0;
        {bit_lt, bit_gt, bit_eq} = 3'b000;
        chk("done_pulse", CW'(done), CW'(1));
        chk("final_cnt", beat_cnt, CW'(W));
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step();
        step();
        chk("rst_outputs", CW'({in_ready, busy, done, res_lt, res_gt, res_eq, err}), CW'(0));
        chk("rst_cnt", beat_cnt, CW'(0));
        rst = 1'b0;
        step();

        // Equal operands
        run_cmp(8'hA5, 8'hA5, 1'b0, -1, 1'b0);
        chk("eq_res", CW'({res_lt, res_gt, res_eq}), CW'(3'b001));
        chk("eq_err", CW'(err), CW'(0));
        step();

        // MSB decides
        run_cmp(8'h80, 8'h7F, 1'b0, -1, 1'b0);
        chk("msb_res", CW'({res_lt, res_gt, res_eq}), CW'(3'b010));
        step();
        chk("hold_res", CW'({res_lt, res_gt, res_eq}), CW'(3'b010));
        step();

        // LSB decides with stalls
        run_cmp(8'h12, 8'h13, 1'b1, -1, 1'b0);
        chk("lsb_res", CW'({res_lt, res_gt, res_eq}), CW'(3'b100));
        step();

        // Illegal code on beat 3
        run_cmp(8'h55, 8'h55, 1'b0, 3, 1'b0);
        chk("ill_res", CW'({res_lt, res_gt, res_eq}), CW'(3'b000));
        chk("ill_err", CW'(err), CW'(1));
        step();
        run_cmp(8'h0F, 8'h0E, 1'b0, -1, 1'b0);
        chk("after_ill_res", CW'({res_lt, res_gt, res_eq}), CW'(3'b010));
        chk("after_ill_err", CW'(err), CW'(0));
        step();

        // Reset mid-operation after 4 beats
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            {bit_lt, bit_gt, bit_eq} = 3'b001;
            in_valid = 1'b1;
            step();
        end
        chk("mid_cnt", beat_cnt, CW'(4));
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("midrst_outputs", CW'({in_ready, busy, done, res_lt, res_gt, res_eq, err}), CW'(0));
        chk("midrst_cnt", beat_cnt, CW'(0));
        for (int i = 0; i < 4; i++) step();
        run_cmp(8'h05, 8'h09, 1'b0, -1, 1'b0);
        chk("postrst_res", CW'({res_lt, res_gt, res_eq}), CW'(3'b100));
        step();

        // Busy guard: start held through COLLECT, DONE and the edge leaving DONE
        run_cmp(8'hC3, 8'hC4, 1'b0, -1, 1'b1);
        chk("guard_res", CW'({res_lt, res_gt, res_eq}), CW'(3'b100));
        step();
        start = 1'b0;
        chk("guard_idle", CW'(busy), CW'(0));
        step();
        step();
        chk("guard_hold", CW'({res_lt, res_gt, res_eq, busy, done}), CW'(5'b10000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
